quadrature_generator: RTL and testbench



---
 rtl/quadrature_generator.sv | 132 +++++++++++++
 tb/tb_quadrature_generator.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/quadrature_generator.sv
// quadrature_generator: emits a commanded burst of quadrature A/B edges at a programmed rate.
// Latency: first edge P cycles after start is accepted; done pulses the cycle after the last edge.
// Backpressure: none; start is taken only in IDLE, and a start in RUN or DONE is dropped, not queued.
//
// Ports: clk, reset (sync, active-high); start/stop command strobes; dir (1=CW, A leads B);
//   steps (edges to emit); period (cycles per edge, 0 treated as 1); A/B phase outputs;
//   busy (RUN); done (1-cycle pulse); count (signed-wrap position); Z (index pulse).
// Optional feature macro: QUAD_INDEX_EN enables the revolution tracker that drives Z.
module quadrature_generator #(
  parameter int PERIOD_W      = 16,
  parameter int STEP_W        = 8,
  parameter int EDGES_PER_REV = 80
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic                dir,
  input  logic [STEP_W-1:0]   steps,
  input  logic [PERIOD_W-1:0] period,
  output logic                A,
  output logic                B,
  output logic                busy,
  output logic                done,
  output logic [7:0]          count,
  output logic                Z
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [PERIOD_W-1:0] P_ONE = PERIOD_W'(1);
  localparam logic [STEP_W-1:0]   S_ONE = STEP_W'(1);

  if (EDGES_PER_REV < 2) begin : g_bad_rev
    $error("EDGES_PER_REV must be at least 2");
  end

  logic [1:0]          state;
  logic                dir_q;
  logic [PERIOD_W-1:0] period_q;
  logic [PERIOD_W-1:0] timer;
  logic [STEP_W-1:0]   remaining;
  logic                a_nxt, b_nxt;
  logic                edge_now;

  // Gray-code stepping: in CW the A line toggles when A==B, otherwise B;
  // CCW is the mirror image. This yields 00-10-11-01 (CW) and 00-01-11-10 (CCW).
  always_comb begin
    a_nxt = A;
    b_nxt = B;
    if (dir_q == (A == B)) a_nxt = ~A;
    else                   b_nxt = ~B;
  end

  // stop beats a coinciding timer expiry, so no edge is produced on that cycle.
  assign edge_now = (state == ST_RUN) && !stop && (timer == period_q - P_ONE);

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      dir_q     <= 1'b0;
      period_q  <= P_ONE;
      timer     <= '0;
      remaining <= '0;
      A         <= 1'b0;
      B         <= 1'b0;
      count     <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            dir_q     <= dir;
            period_q  <= (period == '0) ? P_ONE : period;
            remaining <= steps;
            timer     <= '0;
            state     <= (steps == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state <= ST_IDLE;
          end else if (edge_now) begin
            A         <= a_nxt;
            B         <= b_nxt;
            count     <= dir_q ? count + 8'd1 : count - 8'd1;
            remaining <= remaining - S_ONE;
            timer     <= '0;
            if (remaining == S_ONE) state <= ST_DONE;
          end else begin
            timer <= timer + P_ONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef QUAD_INDEX_EN
  localparam int REV_W = $clog2(EDGES_PER_REV);
  localparam logic [REV_W-1:0] REV_MAX = REV_W'(EDGES_PER_REV - 1);
  localparam logic [REV_W-1:0] REV_ONE = REV_W'(1);

  logic [REV_W-1:0] rev;
  logic [REV_W-1:0] rev_nxt;

  always_comb begin
    rev_nxt = rev;
    if (dir_q) rev_nxt = (rev == REV_MAX) ? '0 : rev + REV_ONE;
    else       rev_nxt = (rev == '0) ? REV_MAX : rev - REV_ONE;
  end

  // Z is computed from the post-edge rev/AB so it lands on the same clock as A/B.
  always_ff @(posedge clk) begin
    if (reset) begin
      rev <= '0;
      Z   <= 1'b0;
    end else if (edge_now) begin
      rev <= rev_nxt;
      Z   <= (rev_nxt == '0) && !a_nxt && !b_nxt;
    end
  end
`else
  assign Z = 1'b0;
`endif

endmodule

// File: tb/tb_quadrature_generator.sv
// tb_quadrature_generator: directed bench for quadrature_generator.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_quadrature_generator;

  logic        clk = 1'b0;
  logic        reset, start, stop, dir;
  logic [7:0]  steps;
  logic [15:0] period;
  logic        A, B, busy, done, Z;
  logic [7:0]  count;

  int errors = 0;
  int checks = 0;

  logic [1:0] cw_seq  [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
  logic [1:0] ccw_seq [4] = '{2'b01, 2'b11, 2'b10, 2'b00};

  quadrature_generator #(.PERIOD_W(16), .STEP_W(8), .EDGES_PER_REV(80)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .dir(dir),
    .steps(steps), .period(period), .A(A), .B(B), .busy(busy), .done(done),
    .count(count), .Z(Z)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; stop = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  // Presents a command and returns just after the accepting edge.
  task automatic issue(input logic d, input logic [7:0] s, input logic [15:0] p);
    dir = d; steps = s; period = p; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    dir = 1'b0; steps = 8'd0; period = 16'd0;
    do_reset();
    tick();
    checks++;
    if ({A, B, busy, done, Z} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 00000", {A, B, busy, done, Z});
    end
    checks++;
    if (count !== 8'd0) begin
      errors++; $display("FAIL reset_count: got %0d expected 0", count);
    end
  endtask

  task automatic test_cw();
    do_reset();
    issue(1'b1, 8'd8, 16'd4);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL cw_busy_accept: got %b expected 1", busy); end
    for (int c = 1; c <= 32; c++) begin
      tick();
      if (c % 4 == 0) begin
        checks++;
        if ({A, B} !== cw_seq[(c/4 - 1) % 4]) begin
          errors++; $display("FAIL cw_ab c=%0d: got %b expected %b", c, {A, B}, cw_seq[(c/4 - 1) % 4]);
        end
        checks++;
        if (count !== 8'(c/4)) begin
          errors++; $display("FAIL cw_count c=%0d: got %0d expected %0d", c, count, c/4);
        end
      end
      checks++;
      if (busy !== (c < 32)) begin errors++; $display("FAIL cw_busy c=%0d: got %b", c, busy); end
      checks++;
      if (done !== (c == 32)) begin errors++; $display("FAIL cw_done c=%0d: got %b", c, done); end
    end
    tick();
    checks++;
    if ({done, busy} !== 2'b00 || count !== 8'd8) begin
      errors++; $display("FAIL cw_after: got done=%b busy=%b count=%0d expected 0 0 8", done, busy, count);
    end
  endtask

  task automatic test_ccw_wrap();
    do_reset();
    issue(1'b0, 8'd3, 16'd1);
    for (int c = 1; c <= 3; c++) begin
      tick();
      checks++;
      if ({A, B} !== ccw_seq[c-1]) begin
        errors++; $display("FAIL ccw_ab c=%0d: got %b expected %b", c, {A, B}, ccw_seq[c-1]);
      end
      checks++;
      if (count !== 8'(256 - c)) begin
        errors++; $display("FAIL ccw_count c=%0d: got %0d expected %0d", c, count, 256 - c);
      end
      checks++;
      if (done !== (c == 3)) begin errors++; $display("FAIL ccw_done c=%0d: got %b", c, done); end
    end
    tick();
    checks++;
    if ({done, busy} !== 2'b00) begin
      errors++; $display("FAIL ccw_single_done: got done=%b busy=%b expected 0 0", done, busy);
    end
  endtask

  task automatic test_abort();
    do_reset();
    issue(1'b1, 8'd10, 16'd5);
    for (int c = 1; c <= 11; c++) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++; $display("FAIL abort_flags: got busy=%b done=%b expected 0 0", busy, done);
    end
    checks++;
    if (count !== 8'd2 || {A, B} !== 2'b11) begin
      errors++; $display("FAIL abort_pos: got count=%0d ab=%b expected 2 11", count, {A, B});
    end
    issue(1'b0, 8'd1, 16'd1);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL abort_restart: got busy=%b expected 1", busy); end
    tick();
    checks++;
    if ({A, B} !== 2'b10 || count !== 8'd1 || done !== 1'b1) begin
      errors++; $display("FAIL abort_next_cmd: got ab=%b count=%0d done=%b expected 10 1 1", {A, B}, count, done);
    end
  endtask

  task automatic test_degenerate();
    do_reset();
    issue(1'b1, 8'd0, 16'd7);
    checks++;
    if ({busy, done, A, B} !== 4'b0100) begin
      errors++; $display("FAIL zero_steps: got busy,done,ab=%b expected 0100", {busy, done, A, B});
    end
    tick();
    checks++;
    if ({busy, done, A, B} !== 4'b0000) begin
      errors++; $display("FAIL zero_steps_after: got busy,done,ab=%b expected 0000", {busy, done, A, B});
    end
    issue(1'b1, 8'd4, 16'd0);
    for (int c = 1; c <= 4; c++) begin
      tick();
      checks++;
      if ({A, B} !== cw_seq[c-1] || count !== 8'(c)) begin
        errors++; $display("FAIL period0 c=%0d: got ab=%b count=%0d expected %b %0d", c, {A, B}, count, cw_seq[c-1], c);
      end
      checks++;
      if (done !== (c == 4)) begin errors++; $display("FAIL period0_done c=%0d: got %b", c, done); end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    issue(1'b1, 8'd6, 16'd2);
    for (int c = 1; c <= 12; c++) begin
      if (c == 3 || c == 7) begin
        start = 1'b1; dir = 1'b0; steps = 8'd100; period = 16'd1;
      end else begin
        start = 1'b0;
      end
      tick();
      checks++;
      if (done !== (c == 12)) begin errors++; $display("FAIL ignore_done c=%0d: got %b", c, done); end
    end
    checks++;
    if (count !== 8'd6 || {A, B} !== 2'b11) begin
      errors++; $display("FAIL ignore_pos: got count=%0d ab=%b expected 6 11", count, {A, B});
    end
    tick();
    checks++;
    if ({busy, done} !== 2'b00 || count !== 8'd6) begin
      errors++; $display("FAIL ignore_not_queued: got busy=%b done=%b count=%0d expected 0 0 6", busy, done, count);
    end
  endtask

  task automatic test_reset_mid_run();
    issue(1'b1, 8'd5, 16'd3);
    for (int c = 1; c <= 3; c++) tick();
    checks++;
    if (count !== 8'd7 || {A, B} !== 2'b01) begin
      errors++; $display("FAIL midrun_pre: got count=%0d ab=%b expected 7 01", count, {A, B});
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({A, B, busy, done, Z} !== 5'b0 || count !== 8'd0) begin
      errors++; $display("FAIL midrun_reset: got flags=%b count=%0d expected 00000 0", {A, B, busy, done, Z}, count);
    end
  endtask

  task automatic test_index();
    logic exp_z;
    do_reset();
    issue(1'b1, 8'd160, 16'd1);
    for (int k = 1; k <= 160; k++) begin
      tick();
`ifdef QUAD_INDEX_EN
      exp_z = (k == 80) || (k == 160);
`else
      exp_z = 1'b0;
`endif
      checks++;
      if (Z !== exp_z) begin errors++; $display("FAIL index_z k=%0d: got %b expected %b", k, Z, exp_z); end
    end
    checks++;
    if (count !== 8'd160 || done !== 1'b1) begin
      errors++; $display("FAIL index_end: got count=%0d done=%b expected 160 1", count, done);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; dir = 1'b0; steps = 8'd0; period = 16'd0;
    test_reset();
    test_cw();
    test_ccw_wrap();
    test_abort();
    test_degenerate();
    test_back_to_back();
    test_reset_mid_run();
    test_index();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
